// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receiver:
// FSM states, default protocol timing, command bytes and the parity rule.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    WAIT1   = 3'd3,
    SHIFT   = 3'd4,
    FINISH  = 3'd5
  } ps2_state_e;

  // Default timing, all in units of the shared 1 us strobe
  localparam int INHIBIT_US_DEF    = 100;
  localparam int START_US_DEF      = 20;
  localparam int START_TMO_US_DEF  = 15000;
  localparam int PACKET_TMO_US_DEF = 2000;
  localparam int TW_DEF            = 14;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_ENABLE   = 8'hF4;

  // Odd parity: data plus parity always carries an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-collector PS/2 line, with a
// one-cycle falling-edge pulse taken from the synchronized level.
module ps2_line_sync (
  input  logic clk6x,
  input  logic resetn,
  input  logic pin,
  output logic line_s,
  output logic line_fe
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  // Reset to the released (high) level so no edge is reported out of reset
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      meta_p0 <= pin;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign line_s  = sync_p1;
  assign line_fe = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the start bit,
// shifts out data/parity/stop on device clock falls and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_US    = INHIBIT_US_DEF,
  parameter int START_US      = START_US_DEF,
  parameter int START_TMO_US  = START_TMO_US_DEF,
  parameter int PACKET_TMO_US = PACKET_TMO_US_DEF,
  parameter int TW            = TW_DEF
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       ps2clk_drvlow,
  output logic       ps2data_drvlow,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_noack
);

  localparam logic [TW-1:0] INHIBIT_T    = TW'(INHIBIT_US);
  localparam logic [TW-1:0] START_T      = TW'(START_US);
  localparam logic [TW-1:0] START_TMO_T  = TW'(START_TMO_US);
  localparam logic [TW-1:0] PACKET_TMO_T = TW'(PACKET_TMO_US);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    sh_q, sh_d;
  logic          clk_drv_q, clk_drv_d;
  logic          data_drv_q, data_drv_d;
  logic          err_to_q, err_to_d;
  logic          err_na_q, err_na_d;

  logic clk_s_unused;
  logic clk_fe;
  logic data_s;
  logic data_fe_unused;

  ps2_line_sync u_clk_sync (
    .clk6x   (clk6x),
    .resetn  (resetn),
    .pin     (ps2clk_i),
    .line_s  (clk_s_unused),
    .line_fe (clk_fe)
  );

  ps2_line_sync u_data_sync (
    .clk6x   (clk6x),
    .resetn  (resetn),
    .pin     (ps2data_i),
    .line_s  (data_s),
    .line_fe (data_fe_unused)
  );

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_na_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      err_to_q   <= err_to_d;
      err_na_q   <= err_na_d;
    end
  end

  // Frame payload needs no reset: it is always loaded on accept
  always_ff @(posedge clk6x) begin
    sh_q <= sh_d;
  end

  // Microsecond timer restarts on every state change and saturates
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if (ck1us && (timer_q != '1)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    err_to_d   = err_to_q;
    err_na_d   = err_na_q;
    unique case (state_q)
      IDLE: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        if (tx_valid) begin
          sh_d      = {odd_parity(tx_data), tx_data};
          cnt_d     = '0;
          err_to_d  = 1'b0;
          err_na_d  = 1'b0;
          clk_drv_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_q >= INHIBIT_T) begin
          data_drv_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        // Releasing clock with data still low presents the start bit
        if (timer_q >= START_T) begin
          clk_drv_d = 1'b0;
          state_d   = WAIT1;
        end
      end
      WAIT1: begin
        if (clk_fe) begin
          data_drv_d = ~sh_q[0];
          sh_d       = sh_q >> 1;
          cnt_d      = 4'd1;
          state_d    = SHIFT;
        end else if (timer_q >= START_TMO_T) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          err_to_d   = 1'b1;
          state_d    = FINISH;
        end
      end
      SHIFT: begin
        // A falling edge takes priority over a coincident timeout
        if (clk_fe) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q <= 4'd8) begin
            data_drv_d = ~sh_q[0];
            sh_d       = sh_q >> 1;
          end else if (cnt_q == 4'd9) begin
            data_drv_d = 1'b0;
          end else begin
            data_drv_d = 1'b0;
            err_na_d   = data_s;
            state_d    = FINISH;
          end
        end else if (timer_q >= PACKET_TMO_T) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          err_to_d   = 1'b1;
          state_d    = FINISH;
        end
      end
      FINISH: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  assign tx_ready       = resetn && (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign ps2clk_drvlow  = clk_drv_q;
  assign ps2data_drvlow = data_drv_q;
  assign err_timeout    = err_to_q;
  assign err_noack      = err_na_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out,
// a scoreboard queue holds expected outcomes popped on every done pulse.
module tb_ps2_host_tx;

  localparam int HALF = 80;   // device clock half period in clk6x cycles (40 us)
  localparam int QTR  = 20;

  typedef struct {
    logic [7:0] data;
    int         edges;
    bit         to;
    bit         noack;
  } exp_t;

  logic       clk6x;
  logic       resetn;
  logic       ck1us;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2clk_i;
  logic       ps2data_i;
  logic       ps2clk_drvlow;
  logic       ps2data_drvlow;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_noack;

  logic dev_clk_low;
  logic dev_data_low;

  int   n_chk;
  int   n_pass;
  int   n_sent;
  int   acc_cnt;
  int   dev_edges;
  bit   dev_ack;
  int   dev_edge_cnt;
  logic [9:0] obs_bits;
  int   obs_n;
  exp_t exp_q[$];

  // Open-collector bus: a line is high only when nobody pulls it low
  assign ps2clk_i  = !(ps2clk_drvlow | dev_clk_low);
  assign ps2data_i = !(ps2data_drvlow | dev_data_low);

  ps2_host_tx dut (
    .clk6x          (clk6x),
    .resetn         (resetn),
    .ck1us          (ck1us),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .ps2clk_i       (ps2clk_i),
    .ps2data_i      (ps2data_i),
    .ps2clk_drvlow  (ps2clk_drvlow),
    .ps2data_drvlow (ps2data_drvlow),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout),
    .err_noack      (err_noack)
  );

  initial begin
    clk6x = 1'b0;
    forever #10 clk6x = ~clk6x;
  end

  // Time is compressed: one microsecond strobe every second clk6x cycle
  initial begin
    ck1us = 1'b0;
    forever begin
      @(posedge clk6x);
      #2 ck1us = ~ck1us;
    end
  end

  always @(posedge clk6x) begin
    if (resetn && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic void check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endfunction

  function automatic void fail(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired", name);
  endfunction

  // Reference frame as the device sees it: data LSB first, odd parity, stop
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = (((int'(d) >> i) % 2) == 1);
      ones += ((int'(d) >> i) % 2);
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // ---------------- device model ----------------
  task automatic dev_wait(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk6x);
      if (!resetn) ab = 1'b1;
    end
  endtask

  task automatic run_device();
    bit ab;
    ab = 1'b0;
    obs_n = 0;
    obs_bits = '0;
    dev_edge_cnt = 0;
    check("start_bit", ps2data_i, 0);
    for (int e = 1; e <= dev_edges && !ab; e++) begin
      if (e == 11 && dev_ack) dev_data_low = 1'b1;
      dev_wait(QTR, ab);
      if (ab) break;
      dev_clk_low = 1'b1;
      dev_edge_cnt = e;
      dev_wait(HALF, ab);
      if (ab) break;
      dev_clk_low = 1'b0;
      if (e <= 10) begin
        obs_bits[e-1] = ps2data_i;
        obs_n = e;
      end
      dev_wait(HALF - QTR, ab);
    end
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
  endtask

  initial begin : device
    logic prev_drv;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    prev_drv = 1'b0;
    forever begin
      @(negedge clk6x);
      if (resetn && prev_drv && !ps2clk_drvlow && ps2data_drvlow) run_device();
      prev_drv = ps2clk_drvlow;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    logic prev_drv;
    bit   rel_on, fe_on, chk_idle;
    int   low_cnt, inh_cnt, rel_cnt, fe_cnt;
    logic [9:0] ef, mask;
    prev_drv = 1'b0;
    rel_on = 0; fe_on = 0; chk_idle = 0;
    low_cnt = 0; inh_cnt = 0; rel_cnt = 0; fe_cnt = 0;
    forever begin
      @(negedge clk6x);
      if (!resetn) begin
        rel_on = 0; fe_on = 0; chk_idle = 0;
        low_cnt = 0; inh_cnt = 0; rel_cnt = 0; fe_cnt = 0;
        prev_drv = 1'b0;
        continue;
      end
      if (chk_idle) begin
        check("busy_after_done", busy, 0);
        check("ready_after_done", tx_ready, 1);
        chk_idle = 0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("err_timeout", err_timeout, e.to);
          check("err_noack", err_noack, e.noack);
          check("lines_released", {ps2clk_drvlow, ps2data_drvlow}, 0);
          check("busy_at_done", busy, 1);
          check("bits_seen", obs_n, (e.edges > 10) ? 10 : e.edges);
          mask = '0;
          for (int i = 0; i < 10; i++) if (i < e.edges) mask[i] = 1'b1;
          ef = ref_frame(e.data);
          check("frame", obs_bits & mask, ef & mask);
          if (e.edges == 0) check("start_tmo_us", rel_cnt, 15000);
          else if (e.edges < 11) check_range("packet_tmo_us", fe_cnt, 2001, 2002);
        end
        chk_idle = 1;
        rel_on = 0;
        fe_on = 0;
      end else begin
        if (ps2clk_drvlow) begin
          low_cnt += int'(ck1us);
          if (!ps2data_drvlow) inh_cnt += int'(ck1us);
        end
        if (prev_drv && !ps2clk_drvlow && ps2data_drvlow) begin
          check("inhibit_us", inh_cnt, 100);
          check("clk_low_us", low_cnt, 120);
          low_cnt = 0;
          inh_cnt = 0;
          rel_on = 1;
          fe_on = 0;
          rel_cnt = int'(ck1us);
        end else if (rel_on) begin
          rel_cnt += int'(ck1us);
        end
        if (rel_on && !fe_on && dev_clk_low) begin
          fe_on = 1;
          fe_cnt = int'(ck1us);
        end else if (fe_on) begin
          fe_cnt += int'(ck1us);
        end
      end
      prev_drv = ps2clk_drvlow;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int t;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk6x);
      t++;
    end
    if (!tx_ready) fail("ready_wait");
  endtask

  task automatic send(input logic [7:0] d, input int edges, input bit ack);
    exp_t e;
    int t;
    dev_edges = edges;
    dev_ack = ack;
    wait_ready();
    tx_data = d;
    tx_valid = 1'b1;
    e.data = d;
    e.edges = edges;
    e.to = (edges < 11);
    e.noack = (edges >= 11) && !ack;
    exp_q.push_back(e);
    n_sent++;
    t = 0;
    // tx_valid stays up through the transfer; payload changes must not leak in
    while (!done && t < 40000) begin
      @(negedge clk6x);
      t++;
      if (t == 2) tx_data = 8'($urandom);
    end
    tx_valid = 1'b0;
    if (!done) fail("done_wait");
  endtask

  initial begin : stim
    int t;
    n_chk = 0; n_pass = 0; n_sent = 0; acc_cnt = 0;
    dev_edges = 0; dev_ack = 1'b0; dev_edge_cnt = 0;
    obs_bits = '0; obs_n = 0;
    resetn = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk6x);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lines", {ps2clk_drvlow, ps2data_drvlow}, 0);
    check("rst_errs", {err_timeout, err_noack}, 0);
    resetn = 1'b1;
    @(negedge clk6x);
    check("ready_after_rst", tx_ready, 1);

    send(8'hED, 11, 1'b1);
    send(8'hF4, 11, 1'b1);
    send(8'($urandom), 0, 1'b0);
    send(8'($urandom), 5, 1'b1);
    send(8'($urandom), 11, 1'b0);

    // Abort mid-frame with reset after the fourth device clock edge
    dev_edges = 11;
    dev_ack = 1'b1;
    wait_ready();
    tx_data = 8'hED;
    tx_valid = 1'b1;
    n_sent++;
    t = 0;
    while (dev_edge_cnt < 4 && t < 5000) begin
      @(negedge clk6x);
      t++;
    end
    if (dev_edge_cnt < 4) fail("edge4_wait");
    repeat (10) @(negedge clk6x);
    resetn = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk6x);
    check("midrst_lines", {ps2clk_drvlow, ps2data_drvlow}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tx_ready, 0);
    check("midrst_done", done, 0);
    @(negedge clk6x);
    resetn = 1'b1;
    exp_q.delete();
    repeat (200) @(negedge clk6x);

    send(8'hED, 11, 1'b1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 11, 1'($urandom_range(0, 3) != 0));

    repeat (4) @(negedge clk6x);
    check("accept_count", acc_cnt, n_sent);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
